// File: rtl/cnt_monitor.sv
// cnt_monitor: watches a free-running upstream 3-bit counter and its
// terminal-count flag, counts 7->0 wraps and latches sequence / terminal-count
// errors until software clears them.
//
// Optional feature: define CNT_MONITOR_ERRCNT_EN to build the saturating
// error-event counter on err_cnt; otherwise err_cnt is tied to zero.
//
// Ports:
//   clk       in   sole clock, rising edge
//   reset     in   synchronous, active-low reset
//   en        in   sample enable; 0 freezes all state
//   cnt_in    in   [2:0] upstream count value
//   tc_in     in   upstream terminal-count flag (expected high when cnt_in==7)
//   clr_err   in   clears a latched error (only acts in ERROR)
//   wrap_cnt  out  [WRAP_W-1:0] saturating count of observed 7->0 wraps
//   err       out  latched error flag
//   err_code  out  [1:0] bit0 = sequence error, bit1 = terminal-count mismatch
//   state     out  [1:0] IDLE=00, SYNC=01, TRACK=10, ERROR=11
//   err_cnt   out  [3:0] saturating error-event count (0 when feature absent)
module cnt_monitor #(
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [2:0]        cnt_in,
  input  logic              tc_in,
  input  logic              clr_err,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [1:0]        state,
  output logic [3:0]        err_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SYNC  = 2'b01,
    TRACK = 2'b10,
    ERROR = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        prev_q, prev_d;
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;

  logic [2:0]        prev_inc;
  logic              seq_bad;
  logic              tc_bad;

  assign prev_inc = prev_q + 3'd1;
  assign tc_bad   = (tc_in != (cnt_in == 3'd7));

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    wrap_cnt_d = wrap_cnt_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    seq_bad    = 1'b0;

    if (en) begin
      unique case (state_q)
        IDLE: state_d = SYNC;

        SYNC: begin
          prev_d = cnt_in;
          if (tc_bad) begin
            state_d    = ERROR;
            err_d      = 1'b1;
            err_code_d = 2'b10;
          end else begin
            state_d = TRACK;
          end
        end

        TRACK: begin
          // A repeated value also fails this compare, which is intended.
          seq_bad = (cnt_in != prev_inc);
          if (seq_bad || tc_bad) begin
            state_d    = ERROR;
            err_d      = 1'b1;
            err_code_d = {tc_bad, seq_bad};
          end else begin
            prev_d = cnt_in;
            if ((prev_q == 3'd7) && (cnt_in == 3'd0) && (wrap_cnt_q != '1)) begin
              wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
            end
          end
        end

        ERROR: begin
          if (clr_err) begin
            state_d    = SYNC;
            err_d      = 1'b0;
            err_code_d = 2'b00;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      prev_q     <= '0;
      wrap_cnt_q <= '0;
      err_q      <= 1'b0;
      err_code_q <= '0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      wrap_cnt_q <= wrap_cnt_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

`ifdef CNT_MONITOR_ERRCNT_EN
  logic [3:0] err_cnt_q, err_cnt_d;

  // Counts entries into ERROR; clr_err deliberately leaves it alone.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((state_d == ERROR) && (state_q != ERROR) && (err_cnt_q != 4'hF)) begin
      err_cnt_d = err_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

  assign state    = state_q;
  assign wrap_cnt = wrap_cnt_q;
  assign err      = err_q;
  assign err_code = err_code_q;

endmodule

// File: tb/tb_cnt_monitor.sv
module tb_cnt_monitor;

`ifdef CNT_MONITOR_ERRCNT_EN
  localparam int ERRCNT_ON = 1;
`else
  localparam int ERRCNT_ON = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [2:0] cnt_in;
  logic       tc_in;
  logic       clr_err;

  logic [7:0] wrap_cnt;
  logic       err;
  logic [1:0] err_code;
  logic [1:0] state;
  logic [3:0] err_cnt;

  logic [1:0] wrap_cnt2;
  logic       err2;
  logic [1:0] err_code2;
  logic [1:0] state2;
  logic [3:0] err_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cnt_monitor dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .cnt_in   (cnt_in),
    .tc_in    (tc_in),
    .clr_err  (clr_err),
    .wrap_cnt (wrap_cnt),
    .err      (err),
    .err_code (err_code),
    .state    (state),
    .err_cnt  (err_cnt)
  );

  cnt_monitor #(.WRAP_W(2)) dut2 (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .cnt_in   (cnt_in),
    .tc_in    (tc_in),
    .clr_err  (clr_err),
    .wrap_cnt (wrap_cnt2),
    .err      (err2),
    .err_code (err_code2),
    .state    (state2),
    .err_cnt  (err_cnt2)
  );

  function automatic logic [3:0] exp_ec(input int n);
    if (ERRCNT_ON == 0) return 4'd0;
    return (n > 15) ? 4'd15 : 4'(n);
  endfunction

  task automatic step(input logic e, input logic [2:0] c, input logic t, input logic clr);
    en = e; cnt_in = c; tc_in = t; clr_err = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [2:0] c);
    step(1'b1, c, (c == 3'd7), 1'b0);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    step(1'b1, 3'd5, 1'b0, 1'b1);
    step(1'b1, 3'd7, 1'b1, 1'b0);
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state got %b exp 00", state); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
    checks++; if (err_code !== 2'b00) begin errors++; $display("FAIL reset_code got %b exp 00", err_code); end
    checks++; if (wrap_cnt !== 8'd0) begin errors++; $display("FAIL reset_wrap got %0d exp 0", wrap_cnt); end
    checks++; if (err_cnt !== 4'd0) begin errors++; $display("FAIL reset_errcnt got %0d exp 0", err_cnt); end
    reset = 1'b1;
  endtask

  task automatic test_count;
    // first enabled cycle: only IDLE->SYNC, even with a bad tc
    step(1'b1, 3'd7, 1'b0, 1'b0);
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL first_en_state got %b exp 01", state); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL first_en_err got %b exp 0", err); end
    feed(3'd0);
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL sync_to_track got %b exp 10", state); end
    for (int v = 1; v <= 7; v++) feed(3'(v));
    checks++; if (wrap_cnt !== 8'd0) begin errors++; $display("FAIL pre_wrap got %0d exp 0", wrap_cnt); end
    feed(3'd0);
    checks++; if (wrap_cnt !== 8'd1) begin errors++; $display("FAIL first_wrap got %0d exp 1", wrap_cnt); end
    feed(3'd1);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL count_err got %b exp 0", err); end
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL count_state got %b exp 10", state); end
  endtask

  task automatic test_seq_err;
    feed(3'd2);
    feed(3'd3);
    feed(3'd5);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL seq_err got %b exp 1", err); end
    checks++; if (err_code !== 2'b01) begin errors++; $display("FAIL seq_code got %b exp 01", err_code); end
    checks++; if (state !== 2'b11) begin errors++; $display("FAIL seq_state got %b exp 11", state); end
    step(1'b1, 3'd4, 1'b1, 1'b0);
    step(1'b1, 3'd7, 1'b0, 1'b0);
    checks++; if (err_code !== 2'b01) begin errors++; $display("FAIL err_hold_code got %b exp 01", err_code); end
    checks++; if (state !== 2'b11) begin errors++; $display("FAIL err_hold_state got %b exp 11", state); end
    checks++; if (wrap_cnt !== 8'd1) begin errors++; $display("FAIL err_hold_wrap got %0d exp 1", wrap_cnt); end
    checks++; if (err_cnt !== exp_ec(1)) begin errors++; $display("FAIL errcnt_1 got %0d exp %0d", err_cnt, exp_ec(1)); end
    step(1'b1, 3'd0, 1'b0, 1'b1);
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL clr_state got %b exp 01", state); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL clr_err got %b exp 0", err); end
    checks++; if (err_code !== 2'b00) begin errors++; $display("FAIL clr_code got %b exp 00", err_code); end
    checks++; if (wrap_cnt !== 8'd1) begin errors++; $display("FAIL clr_wrap got %0d exp 1", wrap_cnt); end
  endtask

  task automatic test_tc_err;
    feed(3'd5);
    feed(3'd6);
    step(1'b1, 3'd7, 1'b0, 1'b0);
    checks++; if (err_code !== 2'b10) begin errors++; $display("FAIL tc_code got %b exp 10", err_code); end
    checks++; if (state !== 2'b11) begin errors++; $display("FAIL tc_state got %b exp 11", state); end
    step(1'b1, 3'd0, 1'b0, 1'b1);
    step(1'b1, 3'd3, 1'b1, 1'b0);
    checks++; if (err_code !== 2'b10) begin errors++; $display("FAIL sync_tc_code got %b exp 10", err_code); end
    step(1'b1, 3'd0, 1'b0, 1'b1);
    feed(3'd2);
    step(1'b1, 3'd4, 1'b1, 1'b0);
    checks++; if (err_code !== 2'b11) begin errors++; $display("FAIL both_code got %b exp 11", err_code); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL both_err got %b exp 1", err); end
    step(1'b1, 3'd0, 1'b0, 1'b1);
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL tc_clr_state got %b exp 01", state); end
  endtask

  task automatic test_clr_no_effect;
    feed(3'd6);
    step(1'b1, 3'd7, 1'b1, 1'b1);
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL clr_track_state got %b exp 10", state); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL clr_track_err got %b exp 0", err); end
    checks++; if (err_cnt !== exp_ec(4)) begin errors++; $display("FAIL errcnt_4 got %0d exp %0d", err_cnt, exp_ec(4)); end
  endtask

  task automatic test_en_hold;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0);
      checks++; if (state !== 2'b10 || err !== 1'b0) begin
        errors++; $display("FAIL en_hold_%0d got state %b err %b exp 10 0", i, state, err);
      end
    end
    feed(3'd0);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL resume_err got %b exp 0", err); end
    checks++; if (wrap_cnt !== 8'd2) begin errors++; $display("FAIL resume_wrap got %0d exp 2", wrap_cnt); end
    checks++; if (wrap_cnt2 !== 2'd2) begin errors++; $display("FAIL resume_wrap2 got %0d exp 2", wrap_cnt2); end
  endtask

  task automatic test_saturation;
    for (int w = 0; w < 5; w++) begin
      for (int v = 1; v <= 7; v++) feed(3'(v));
      feed(3'd0);
      if (w == 1) begin
        checks++; if (wrap_cnt2 !== 2'd3) begin errors++; $display("FAIL sat_mid got %0d exp 3", wrap_cnt2); end
      end
    end
    checks++; if (wrap_cnt2 !== 2'd3) begin errors++; $display("FAIL sat_wrap2 got %0d exp 3", wrap_cnt2); end
    checks++; if (wrap_cnt !== 8'd7) begin errors++; $display("FAIL sat_wrap got %0d exp 7", wrap_cnt); end
    checks++; if (err2 !== 1'b0) begin errors++; $display("FAIL sat_err got %b exp 0", err2); end
    feed(3'd1);
    feed(3'd2);
    reset = 1'b0;
    step(1'b1, 3'd3, 1'b0, 1'b1);
    checks++; if (state !== 2'b00 || state2 !== 2'b00) begin errors++; $display("FAIL mid_rst_state got %b/%b exp 00", state, state2); end
    checks++; if (wrap_cnt !== 8'd0 || wrap_cnt2 !== 2'd0) begin errors++; $display("FAIL mid_rst_wrap got %0d/%0d exp 0", wrap_cnt, wrap_cnt2); end
    checks++; if (err !== 1'b0 || err_code !== 2'b00) begin errors++; $display("FAIL mid_rst_err got %b/%b exp 0/00", err, err_code); end
    checks++; if (err_cnt !== 4'd0 || err_cnt2 !== 4'd0) begin errors++; $display("FAIL mid_rst_errcnt got %0d/%0d exp 0", err_cnt, err_cnt2); end
    reset = 1'b1;
  endtask

  task automatic test_err_cnt;
    step(1'b1, 3'd0, 1'b0, 1'b0);
    feed(3'd0);
    feed(3'd2);
    checks++; if (err_cnt !== exp_ec(1)) begin errors++; $display("FAIL ec_first got %0d exp %0d", err_cnt, exp_ec(1)); end
    step(1'b1, 3'd0, 1'b0, 1'b1);
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL ec_sync got %b exp 01", state); end
    feed(3'd4);
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL ec_track got %b exp 10", state); end
    feed(3'd4);
    checks++; if (err_code !== 2'b01) begin errors++; $display("FAIL repeat_code got %b exp 01", err_code); end
    checks++; if (err_cnt !== exp_ec(2)) begin errors++; $display("FAIL ec_second got %0d exp %0d", err_cnt, exp_ec(2)); end
    reset = 1'b0;
    step(1'b1, 3'd0, 1'b0, 1'b1);
    checks++; if (state !== 2'b00 || err !== 1'b0 || err_code !== 2'b00) begin
      errors++; $display("FAIL err_rst got %b/%b/%b exp 00/0/00", state, err, err_code);
    end
    checks++; if (err_cnt !== 4'd0) begin errors++; $display("FAIL err_rst_cnt got %0d exp 0", err_cnt); end
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; cnt_in = 3'd0; tc_in = 1'b0; clr_err = 1'b0;
    test_reset();
    test_count();
    test_seq_err();
    test_tc_err();
    test_clr_no_effect();
    test_en_hold();
    test_saturation();
    test_err_cnt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
